imem_loader: RTL and testbench

- Upstream stage of the digital top: streams program bytes from the host link into the instruction buffer write port (imem_write_adr, imem_write, imem_in).
- Assembles i_buffer_size instructions of i_width bits into one wide write word.
- Auto-increments the write address and verifies a trailing 8-bit checksum.
- Holds the PAT core in reset while a load is in progress.

---
 rtl/pat_pkg.sv | 23 ++
 rtl/imem_loader_byte_assembler.sv | 40 ++++
 rtl/imem_loader.sv | 141 ++++++++++++++
 tb/tb_imem_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pat_pkg.sv
// Shared definitions for the PAT program-load path: loader states and
// instruction-buffer geometry.
package pat_pkg;

    localparam int I_ADR_WIDTH    = 10;
    localparam int I_WIDTH        = 20;
    localparam int I_BUFFER_SIZE  = 2;
    localparam int CNT_WIDTH      = I_ADR_WIDTH + 1;
    localparam int IMEM_WORD_W    = I_WIDTH * I_BUFFER_SIZE;
    localparam int BYTES_PER_WORD = (IMEM_WORD_W + 7) / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

    function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Collects host bytes, least-significant first, into one instruction-buffer
// write word and flags acceptance of the word's final byte.
module byte_assembler #(
    parameter int WORD_W = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_valid,
    input  logic [7:0]        i_byte,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_complete
);

    localparam int NB = (WORD_W + 7) / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    logic [IW-1:0]   r_idx;
    logic [NB*8-1:0] r_word;
    logic            w_last;

    assign w_last          = (r_idx == IW'(NB - 1));
    assign o_word_complete = i_valid && w_last;
    // Pad bits of the top byte exist only in the holding register.
    assign o_word          = r_word[WORD_W-1:0];

    // Byte index and word register; the index wraps after the final byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (i_clear) begin
            r_idx  <= '0;
        end else if (i_valid) begin
            r_word[{r_idx, 3'b000} +: 8] <= i_byte;
            r_idx <= w_last ? '0 : r_idx + IW'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams host bytes into the instruction buffer as wide words, auto-increments
// the write address, verifies a trailing checksum and holds the core meanwhile.
module imem_loader
    import pat_pkg::*;
#(
    parameter int i_adr_width   = I_ADR_WIDTH,
    parameter int i_width       = I_WIDTH,
    parameter int i_buffer_size = I_BUFFER_SIZE,
    parameter int cnt_width     = CNT_WIDTH
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [i_adr_width-1:0]             start_adr,
    input  logic [cnt_width-1:0]               word_count,
    input  logic [7:0]                         byte_in,
    input  logic                               byte_valid,
    output logic                               byte_ready,
    output logic [i_adr_width-1:0]             imem_write_adr,
    output logic                               imem_write,
    output logic [i_buffer_size*i_width-1:0]   imem_in,
    output logic                               core_hold,
    output logic                               done,
    output logic                               load_ok
);

    localparam int W = i_buffer_size * i_width;

    loader_state_t          r_state;
    loader_state_t          w_next;
    logic [i_adr_width-1:0] r_adr;
    logic [cnt_width-1:0]   r_remaining;
    logic [7:0]             r_sum;
    logic                   r_write;
    logic                   r_done;
    logic                   r_load_ok;
    logic                   r_core_hold;

    logic                   w_byte_ready;
    logic                   w_accept;
    logic                   w_data_accept;
    logic                   w_start_ok;
    logic                   w_word_complete;
    logic [W-1:0]           w_word;

    // Ready is withheld during the strobe so the address cannot move under a write.
    assign w_byte_ready  = ((r_state == LOAD) && !r_write) || (r_state == CHECK);
    assign w_accept      = byte_valid && w_byte_ready;
    assign w_data_accept = w_accept && (r_state == LOAD);
    assign w_start_ok    = start && (r_state == IDLE);

    byte_assembler #(
        .WORD_W (W)
    ) u_asm (
        .clk             (clk),
        .reset           (reset),
        .i_clear         (w_start_ok),
        .i_valid         (w_data_accept),
        .i_byte          (byte_in),
        .o_word          (w_word),
        .o_word_complete (w_word_complete)
    );

    // Next-state selection.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (word_count != '0) ? LOAD : CHECK;
                end else begin
                    w_next = IDLE;
                end
            end
            LOAD: begin
                if (r_write && (r_remaining == cnt_width'(1))) begin
                    w_next = CHECK;
                end else begin
                    w_next = LOAD;
                end
            end
            CHECK: begin
                if (w_accept) begin
                    w_next = DONE;
                end else begin
                    w_next = CHECK;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register plus address, count, checksum and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_adr       <= '0;
            r_remaining <= '0;
            r_sum       <= '0;
            r_write     <= 1'b0;
            r_done      <= 1'b0;
            r_load_ok   <= 1'b0;
            r_core_hold <= 1'b0;
        end else begin
            r_state <= w_next;
            r_write <= w_word_complete;
            r_done  <= (w_next == DONE);
            if (w_start_ok) begin
                r_adr       <= start_adr;
                r_remaining <= word_count;
                r_sum       <= '0;
                r_core_hold <= 1'b1;
                r_load_ok   <= 1'b0;
            end
            if (w_data_accept) begin
                r_sum <= sum8(r_sum, byte_in);
            end
            // Advance only after the strobe cycle has presented the address.
            if (r_write) begin
                r_adr       <= r_adr + i_adr_width'(1);
                r_remaining <= r_remaining - cnt_width'(1);
            end
            if (w_accept && (r_state == CHECK)) begin
                r_load_ok <= (byte_in == r_sum);
            end
            if (r_state == DONE) begin
                r_core_hold <= 1'b0;
            end
        end
    end

    assign byte_ready     = w_byte_ready;
    assign imem_write_adr = r_adr;
    assign imem_write     = r_write;
    assign imem_in        = w_word;
    assign core_hold      = r_core_hold;
    assign done           = r_done;
    assign load_ok        = r_load_ok;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized loads of imem_loader checked against a word-level
// model of the expected write sequence and checksum verdict.
module tb_imem_loader;

    localparam int AW = 10;
    localparam int CW = 11;
    localparam int W  = 40;
    localparam int B  = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] start_adr;
    logic [CW-1:0] word_count;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic [AW-1:0] imem_write_adr;
    logic          imem_write;
    logic [W-1:0]  imem_in;
    logic          core_hold;
    logic          done;
    logic          load_ok;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int accept_cnt = 0;
    logic [AW-1:0] got_adr[$];
    logic [W-1:0]  got_dat[$];
    logic [7:0]    dq[$];

    imem_loader dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .start_adr      (start_adr),
        .word_count     (word_count),
        .byte_in        (byte_in),
        .byte_valid     (byte_valid),
        .byte_ready     (byte_ready),
        .imem_write_adr (imem_write_adr),
        .imem_write     (imem_write),
        .imem_in        (imem_in),
        .core_hold      (core_hold),
        .done           (done),
        .load_ok        (load_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_write === 1'b1) begin
            got_adr.push_back(imem_write_adr);
            got_dat.push_back(imem_in);
            check("ready_low_in_strobe", 64'(byte_ready), 64'd0);
        end
        if (done === 1'b1) done_cnt++;
    end

    always @(posedge clk) begin
        if (!reset && byte_valid && byte_ready) accept_cnt++;
    end

    task automatic send_byte(input logic [7:0] b, input int stall, input bit pulse_start);
        bit acc;
        int budget;
        acc = 1'b0;
        budget = 0;
        while (!acc && budget < 200) begin
            @(negedge clk);
            start = pulse_start && (budget == 0);
            if (start) start_adr = ~start_adr;
            if ($urandom_range(99) < stall) begin
                byte_valid = 1'b0;
            end else begin
                byte_valid = 1'b1;
                byte_in    = b;
                acc        = byte_ready;
            end
            @(posedge clk);
            budget++;
        end
        if (!acc) check("byte_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_load(input logic [AW-1:0] adr, input int n, input logic [7:0] chk,
                            input int stall, input bit mid, input bit stray);
        logic [7:0]    sum;
        logic [W-1:0]  exp_dat;
        logic [AW-1:0] exp_adr;
        bit            exp_ok;
        bit            seen;
        int            nb;
        int            acc0;
        sum  = 8'd0;
        nb   = n * B;
        seen = 1'b0;
        got_adr.delete();
        got_dat.delete();
        done_cnt = 0;
        acc0 = accept_cnt;
        if (stray) begin
            repeat (3) begin
                @(negedge clk);
                byte_valid = 1'b1;
                byte_in    = 8'hA5;
                check("idle_not_ready", 64'(byte_ready), 64'd0);
            end
        end
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b1;
        start_adr  = adr;
        word_count = CW'(n);
        @(negedge clk);
        start = 1'b0;
        check("core_hold_after_start", 64'(core_hold), 64'd1);
        check("load_ok_cleared", 64'(load_ok), 64'd0);
        for (int i = 0; i < nb; i++) begin
            sum = sum + dq[i];
            send_byte(dq[i], stall, mid && (i == nb / 2));
        end
        send_byte(chk, stall, 1'b0);
        exp_ok = (chk == sum);
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            byte_valid = 1'b0;
            start      = 1'b0;
            if (done === 1'b1) seen = 1'b1;
        end
        check("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            check("load_ok_at_done", 64'(load_ok), 64'(exp_ok));
            check("core_hold_at_done", 64'(core_hold), 64'd1);
            @(negedge clk);
            check("core_hold_released", 64'(core_hold), 64'd0);
            check("done_one_cycle", 64'(done), 64'd0);
            check("load_ok_holds", 64'(load_ok), 64'(exp_ok));
        end
        check("done_count", 64'(done_cnt), 64'd1);
        check("write_count", 64'(got_adr.size()), 64'(n));
        for (int w = 0; w < n && w < got_adr.size(); w++) begin
            exp_adr = AW'(int'(adr) + w);
            exp_dat = '0;
            for (int k = 0; k < B; k++) exp_dat = exp_dat | (W'(dq[w * B + k]) << (8 * k));
            check("write_adr", 64'(got_adr[w]), 64'(exp_adr));
            check("write_data", 64'(got_dat[w]), 64'(exp_dat));
        end
        check("bytes_accepted", 64'(accept_cnt - acc0), 64'(nb + 1));
    endtask

    initial begin
        int n;
        logic [7:0] s;
        reset = 1'b1; start = 1'b0; start_adr = '0; word_count = '0;
        byte_in = 8'h00; byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_byte_ready", 64'(byte_ready), 64'd0);
        check("rst_imem_write", 64'(imem_write), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_load_ok", 64'(load_ok), 64'd0);
        check("rst_core_hold", 64'(core_hold), 64'd0);
        check("rst_adr", 64'(imem_write_adr), 64'd0);
        check("rst_imem_in", 64'(imem_in), 64'd0);
        reset = 1'b0;

        // Basic load, good then bad checksum.
        dq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        run_load(10'h010, 1, 8'h0F, 0, 1'b0, 1'b0);
        check("basic_word", 64'(got_dat.size() > 0 ? got_dat[0] : '0), 64'h0504030201);
        run_load(10'h010, 1, 8'h10, 0, 1'b0, 1'b0);

        // Address wrap across the top of the buffer.
        dq.delete();
        repeat (10) dq.push_back(8'hFF);
        run_load(10'h3FF, 2, 8'hF6, 0, 1'b0, 1'b0);

        // Stalls, a stray start mid-load and bytes offered while idle.
        dq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        run_load(10'h010, 1, 8'h0F, 40, 1'b1, 1'b1);

        // Reset after the seventh byte of a three-word load.
        dq.delete();
        repeat (15) dq.push_back(8'($urandom));
        got_adr.delete(); got_dat.delete();
        @(negedge clk);
        start = 1'b1; start_adr = 10'h100; word_count = CW'(3);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 7; i++) send_byte(dq[i], 0, 1'b0);
        @(negedge clk);
        byte_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_ready", 64'(byte_ready), 64'd0);
        check("mid_rst_core_hold", 64'(core_hold), 64'd0);
        check("mid_rst_adr", 64'(imem_write_adr), 64'd0);
        check("mid_rst_imem_in", 64'(imem_in), 64'd0);
        check("mid_rst_write", 64'(imem_write), 64'd0);
        repeat (8) @(negedge clk);
        check("mid_rst_writes", 64'(got_adr.size()), 64'd1);
        if (got_adr.size() > 0) begin
            check("mid_rst_adr0", 64'(got_adr[0]), 64'h100);
            check("mid_rst_dat0", 64'(got_dat[0]),
                  {24'd0, dq[4], dq[3], dq[2], dq[1], dq[0]});
        end
        run_load(10'h100, 3, 8'h00, 20, 1'b0, 1'b0);

        // Start and reset together: reset wins.
        @(negedge clk);
        reset = 1'b1; start = 1'b1; word_count = CW'(1);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check("start_under_reset", 64'(core_hold), 64'd0);

        // Empty load consumes only the checksum byte.
        dq.delete();
        run_load(10'h020, 0, 8'h00, 0, 1'b0, 1'b1);

        // Randomized loads.
        repeat (4) begin
            n = $urandom_range(4, 1);
            dq.delete();
            s = 8'd0;
            for (int i = 0; i < n * B; i++) begin
                dq.push_back(8'($urandom));
                s = s + dq[i];
            end
            if ($urandom_range(1) == 0) s = s + 8'd1;
            run_load(AW'($urandom), n, s, 30, 1'($urandom_range(1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
